// File: rtl/ilv_downstream_sink.sv
// Bench-side consumer for the interleaver rdy/acpt port: programmable backpressure, beat capture,
// checksum and protocol-violation flags. Stall statistics are built only with ILV_SINK_STALL_STATS_EN.
module ilv_downstream_sink #(
  parameter int          DATA_W     = 8,
  parameter int          CNT_W      = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          STALL_LONG = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ds_rdy,
  input  logic [DATA_W-1:0] ds_data,
  output logic              ds_acpt,
  input  logic [1:0]        mode,
  input  logic [3:0]        wait_cycles,
  output logic [DATA_W-1:0] data_out,
  output logic              data_vld,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [DATA_W-1:0] checksum,
  output logic [1:0]        proto_err,
  output logic [15:0]       short_stalls,
  output logic [15:0]       long_stalls,
  output logic [7:0]        max_stall
);
  localparam logic [1:0] MODE_STREAM = 2'b00;
  localparam logic [1:0] MODE_DELAY  = 2'b01;
  localparam logic [1:0] MODE_RANDOM = 2'b10;
  localparam logic [1:0] MODE_BLOCK  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACPT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              acpt_q, acpt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [DATA_W-1:0] data_q, sum_q, stall_data_q;
  logic              vld_q, stall_q;
  logic [CNT_W-1:0]  beat_q;
  logic [1:0]        err_q, err_d;
  logic              xfer, stall;

  assign xfer   = ds_rdy && acpt_q;
  assign stall  = ds_rdy && !acpt_q;
  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign err_d  = err_q | {stall_q && !ds_rdy,
                           stall_q && ds_rdy && (ds_data != stall_data_q)};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acpt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        case (mode)
          MODE_STREAM: acpt_d = 1'b1;
          MODE_RANDOM: acpt_d = lfsr_q[0];
          MODE_DELAY: begin
            if (stall) begin
              cnt_d = wait_cycles;
              if (wait_cycles == 4'd0) begin
                state_d = ST_ACPT;
                acpt_d  = 1'b1;
              end else begin
                state_d = ST_WAIT;
              end
            end
          end
          MODE_BLOCK: acpt_d = 1'b0;
          default:    acpt_d = 1'b0;
        endcase
      end
      ST_WAIT: begin
        if (!ds_rdy) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = ST_ACPT;
          acpt_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACPT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acpt_q       <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      data_q       <= '0;
      sum_q        <= '0;
      stall_data_q <= '0;
      vld_q        <= 1'b0;
      stall_q      <= 1'b0;
      beat_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acpt_q  <= acpt_d;
      lfsr_q  <= lfsr_d;
      vld_q   <= xfer;
      stall_q <= stall;
      err_q   <= err_d;
      if (stall) stall_data_q <= ds_data;
      if (xfer) begin
        data_q <= ds_data;
        beat_q <= beat_q + CNT_W'(1);
        sum_q  <= sum_q + ds_data;
      end
    end
  end

  assign ds_acpt   = acpt_q;
  assign data_out  = data_q;
  assign data_vld  = vld_q;
  assign beat_cnt  = beat_q;
  assign checksum  = sum_q;
  assign proto_err = err_q;

`ifdef ILV_SINK_STALL_STATS_EN
  localparam logic [7:0] LONG_TH = 8'(STALL_LONG);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0]  slen_q, max_q;
  logic [15:0] short_q, long_q;

  // A stall is only classified when a transfer ends it; rdy withdrawal discards it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slen_q  <= '0;
      max_q   <= '0;
      short_q <= '0;
      long_q  <= '0;
    end else if (stall) begin
      slen_q <= sat_inc8(slen_q);
    end else begin
      slen_q <= '0;
      if (xfer && (slen_q != 8'd0)) begin
        if (slen_q <= LONG_TH) short_q <= sat_inc16(short_q);
        else                   long_q  <= sat_inc16(long_q);
        if (slen_q > max_q) max_q <= slen_q;
      end
    end
  end

  assign short_stalls = short_q;
  assign long_stalls  = long_q;
  assign max_stall    = max_q;
`else
  assign short_stalls = '0;
  assign long_stalls  = '0;
  assign max_stall    = '0;
`endif

endmodule

// File: tb/tb_ilv_downstream_sink.sv
// Self-checking bench for ilv_downstream_sink: directed scenarios plus a randomized RANDOM-mode run.
module tb_ilv_downstream_sink;
  localparam logic [1:0] M_STREAM = 2'b00;
  localparam logic [1:0] M_DELAY  = 2'b01;
  localparam logic [1:0] M_RANDOM = 2'b10;
  localparam logic [1:0] M_BLOCK  = 2'b11;
`ifdef ILV_SINK_STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ds_rdy = 1'b0;
  logic [7:0]  ds_data = 8'h00;
  logic [1:0]  mode = M_STREAM;
  logic [3:0]  wait_cycles = 4'd0;

  logic        ds_acpt, data_vld;
  logic [7:0]  data_out, checksum, max_stall;
  logic [15:0] beat_cnt, short_stalls, long_stalls;
  logic [1:0]  proto_err;

  logic        b4_acpt, b4_vld;
  logic [7:0]  b4_data, b4_sum, b4_max;
  logic [3:0]  b4_cnt;
  logic [15:0] b4_short, b4_long;
  logic [1:0]  b4_err;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_seen = 0;

  ilv_downstream_sink u_dut (
    .clk(clk), .rst_n(rst_n), .ds_rdy(ds_rdy), .ds_data(ds_data), .ds_acpt(ds_acpt),
    .mode(mode), .wait_cycles(wait_cycles), .data_out(data_out), .data_vld(data_vld),
    .beat_cnt(beat_cnt), .checksum(checksum), .proto_err(proto_err),
    .short_stalls(short_stalls), .long_stalls(long_stalls), .max_stall(max_stall)
  );

  ilv_downstream_sink #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ds_rdy(ds_rdy), .ds_data(ds_data), .ds_acpt(b4_acpt),
    .mode(mode), .wait_cycles(wait_cycles), .data_out(b4_data), .data_vld(b4_vld),
    .beat_cnt(b4_cnt), .checksum(b4_sum), .proto_err(b4_err),
    .short_stalls(b4_short), .long_stalls(b4_long), .max_stall(b4_max)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_vld === 1'b1) vld_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst_n = 1'b0;
    ds_rdy = 1'b0;
    ds_data = 8'h00;
    mode = m;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Present one beat and hold it until accepted; returns the number of stall cycles seen
  task automatic send_beat(input logic [7:0] d, output int stalls, output bit ok);
    ds_rdy = 1'b1;
    ds_data = d;
    stalls = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ds_acpt === 1'b1) begin
        tick();
        ok = 1'b1;
        break;
      end
      stalls++;
      tick();
    end
  endtask

  task automatic test_reset();
    #3;
    mode = M_STREAM;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ds_acpt !== 1'b0) begin n_bad++; $display("FAIL reset_acpt: got %0b want 0", ds_acpt); end
    n_cmp++; if (beat_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
    n_cmp++; if (checksum !== 8'd0) begin n_bad++; $display("FAIL reset_checksum: got %0h want 0", checksum); end
    n_cmp++; if ({data_vld, data_out, proto_err} !== 11'd0) begin n_bad++; $display("FAIL reset_outputs: got vld=%0b data=%0h err=%0b want 0", data_vld, data_out, proto_err); end
    tick();
    tick();
    n_cmp++; if (ds_acpt !== 1'b0) begin n_bad++; $display("FAIL reset_hold_acpt: got %0b want 0", ds_acpt); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int st, bad_stalls;
    bit ok;
    logic [7:0] sum;
    do_reset(M_STREAM);
    tick();
    n_cmp++; if (ds_acpt !== 1'b1) begin n_bad++; $display("FAIL stream_acpt_first: got %0b want 1", ds_acpt); end
    sum = 8'd0;
    bad_stalls = 0;
    for (int i = 1; i <= 16; i++) begin
      send_beat(8'(i), st, ok);
      if (!ok || st != 0) bad_stalls++;
      sum = sum + 8'(i);
    end
    ds_rdy = 1'b0;
    tick();
    n_cmp++; if (bad_stalls != 0) begin n_bad++; $display("FAIL stream_no_stall: got %0d stalled beats want 0", bad_stalls); end
    n_cmp++; if (beat_cnt !== 16'd16) begin n_bad++; $display("FAIL stream_beat_cnt: got %0d want 16", beat_cnt); end
    n_cmp++; if (checksum !== sum) begin n_bad++; $display("FAIL stream_checksum: got %0h want %0h", checksum, sum); end
    n_cmp++; if (proto_err !== 2'b00) begin n_bad++; $display("FAIL stream_proto_err: got %0b want 00", proto_err); end
    n_cmp++; if (b4_cnt !== 4'd0) begin n_bad++; $display("FAIL stream_wrap16: got %0d want 0", b4_cnt); end
  endtask

  task automatic test_delay_short();
    int st, v0;
    bit ok;
    wait_cycles = 4'd3;
    do_reset(M_DELAY);
    tick();
    v0 = vld_seen;
    send_beat(8'hA5, st, ok);
    n_cmp++; if (!ok || st != 4) begin n_bad++; $display("FAIL delay3_stalls: got %0d (ok=%0b) want 4", st, ok); end
    n_cmp++; if (data_out !== 8'hA5 || data_vld !== 1'b1) begin n_bad++; $display("FAIL delay3_capture: got data=%0h vld=%0b want a5/1", data_out, data_vld); end
    ds_rdy = 1'b0;
    n_cmp++; if (ds_acpt !== 1'b0) begin n_bad++; $display("FAIL delay3_acpt_width: got %0b want 0", ds_acpt); end
    repeat (4) tick();
    n_cmp++; if (vld_seen - v0 != 1) begin n_bad++; $display("FAIL delay3_vld_pulses: got %0d want 1", vld_seen - v0); end
    n_cmp++; if (short_stalls !== (STATS ? 16'd1 : 16'd0) || long_stalls !== 16'd0) begin n_bad++; $display("FAIL delay3_short_stalls: got %0d/%0d want %0d/0", short_stalls, long_stalls, STATS); end
    n_cmp++; if (max_stall !== (STATS ? 8'd4 : 8'd0)) begin n_bad++; $display("FAIL delay3_max_stall: got %0d want %0d", max_stall, STATS ? 4 : 0); end
  endtask

  task automatic test_delay_long();
    int st1, st2;
    bit ok1, ok2;
    wait_cycles = 4'd15;
    do_reset(M_DELAY);
    tick();
    send_beat(8'h10, st1, ok1);
    send_beat(8'h20, st2, ok2);
    ds_rdy = 1'b0;
    tick();
    n_cmp++; if (!ok1 || !ok2 || st1 != 16 || st2 != 16) begin n_bad++; $display("FAIL delay15_stalls: got %0d,%0d want 16,16", st1, st2); end
    n_cmp++; if (beat_cnt !== 16'd2 || checksum !== 8'h30) begin n_bad++; $display("FAIL delay15_totals: got cnt=%0d sum=%0h want 2/30", beat_cnt, checksum); end
    n_cmp++; if (long_stalls !== (STATS ? 16'd2 : 16'd0) || short_stalls !== 16'd0) begin n_bad++; $display("FAIL delay15_long_stalls: got long=%0d short=%0d want %0d/0", long_stalls, short_stalls, STATS ? 2 : 0); end
    n_cmp++; if (max_stall !== (STATS ? 8'd16 : 8'd0)) begin n_bad++; $display("FAIL delay15_max_stall: got %0d want %0d", max_stall, STATS ? 16 : 0); end
  endtask

  task automatic test_block();
    do_reset(M_BLOCK);
    ds_rdy = 1'b1;
    ds_data = 8'h11;
    tick();
    ds_data = 8'h22;
    tick();
    n_cmp++; if (proto_err !== 2'b01) begin n_bad++; $display("FAIL block_data_change: got %0b want 01", proto_err); end
    ds_rdy = 1'b0;
    tick();
    tick();
    n_cmp++; if (proto_err !== 2'b11) begin n_bad++; $display("FAIL block_rdy_drop: got %0b want 11", proto_err); end
    n_cmp++; if (beat_cnt !== 16'd0 || ds_acpt !== 1'b0) begin n_bad++; $display("FAIL block_no_transfer: got cnt=%0d acpt=%0b want 0/0", beat_cnt, ds_acpt); end
  endtask

  task automatic test_abort_and_mode_change();
    int st;
    bit ok;
    logic [7:0] sum;
    wait_cycles = 4'd5;
    do_reset(M_DELAY);
    tick();
    ds_rdy = 1'b1;
    ds_data = 8'h3C;
    tick();
    tick();
    ds_rdy = 1'b0;
    tick();
    n_cmp++; if (proto_err !== 2'b10 || beat_cnt !== 16'd0) begin n_bad++; $display("FAIL abort_flags: got err=%0b cnt=%0d want 10/0", proto_err, beat_cnt); end
    wait_cycles = 4'd2;
    tick();
    send_beat(8'h5A, st, ok);
    n_cmp++; if (!ok || st != 3) begin n_bad++; $display("FAIL abort_recover_stalls: got %0d want 3", st); end
    ds_rdy = 1'b0;
    tick();
    wait_cycles = 4'd5;
    ds_rdy = 1'b1;
    ds_data = 8'hC3;
    tick();
    mode = M_STREAM;
    send_beat(8'hC3, st, ok);
    n_cmp++; if (!ok || st + 1 != 6) begin n_bad++; $display("FAIL modechg_current_beat: got %0d stalls want 6", st + 1); end
    ds_rdy = 1'b0;
    tick();
    tick();
    send_beat(8'h77, st, ok);
    n_cmp++; if (!ok || st != 0) begin n_bad++; $display("FAIL modechg_next_stream: got %0d stalls want 0", st); end
    ds_rdy = 1'b0;
    tick();
    sum = 8'h5A + 8'hC3 + 8'h77;
    n_cmp++; if (beat_cnt !== 16'd3 || checksum !== sum) begin n_bad++; $display("FAIL modechg_totals: got cnt=%0d sum=%0h want 3/%0h", beat_cnt, checksum, sum); end
    n_cmp++; if (short_stalls !== (STATS ? 16'd2 : 16'd0) || max_stall !== (STATS ? 8'd6 : 8'd0)) begin n_bad++; $display("FAIL abort_not_counted: got short=%0d max=%0d want %0d/%0d", short_stalls, max_stall, STATS ? 2 : 0, STATS ? 6 : 0); end
  endtask

  task automatic test_random();
    int st, timeouts, total_st, v0;
    bit ok, found;
    logic [7:0] d, last, sum;
    do_reset(M_RANDOM);
    tick();
    sum = 8'd0;
    last = 8'd0;
    timeouts = 0;
    total_st = 0;
    v0 = vld_seen;
    for (int i = 0; i < 1000; i++) begin
      d = 8'($urandom_range(0, 255));
      send_beat(d, st, ok);
      if (!ok) timeouts++;
      total_st += st;
      sum = sum + d;
      last = d;
      if ($urandom_range(0, 3) == 0) begin
        ds_rdy = 1'b0;
        tick();
      end
    end
    ds_rdy = 1'b0;
    tick();
    tick();
    n_cmp++; if (timeouts != 0) begin n_bad++; $display("FAIL random_timeouts: got %0d want 0", timeouts); end
    n_cmp++; if (beat_cnt !== 16'd1000) begin n_bad++; $display("FAIL random_beat_cnt: got %0d want 1000", beat_cnt); end
    n_cmp++; if (checksum !== sum) begin n_bad++; $display("FAIL random_checksum: got %0h want %0h", checksum, sum); end
    n_cmp++; if (data_out !== last || proto_err !== 2'b00) begin n_bad++; $display("FAIL random_last: got data=%0h err=%0b want %0h/00", data_out, proto_err, last); end
    n_cmp++; if (vld_seen - v0 != 1000) begin n_bad++; $display("FAIL random_vld_pulses: got %0d want 1000", vld_seen - v0); end
    n_cmp++; if (total_st == 0) begin n_bad++; $display("FAIL random_backpressure: got %0d stall cycles want >0", total_st); end

    ds_rdy = 1'b1;
    ds_data = 8'hEE;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ds_acpt === 1'b0) begin found = 1'b1; break; end
      tick();
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL midstall_find: got no stall cycle want one within 64"); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ds_acpt !== 1'b0 || beat_cnt !== 16'd0 || checksum !== 8'd0) begin n_bad++; $display("FAIL midstall_reset: got acpt=%0b cnt=%0d sum=%0h want 0/0/0", ds_acpt, beat_cnt, checksum); end
    n_cmp++; if ({data_out, data_vld, proto_err, short_stalls, long_stalls, max_stall} !== 51'd0) begin n_bad++; $display("FAIL midstall_reset_rest: got data=%0h err=%0b stats=%0d/%0d/%0d want 0", data_out, proto_err, short_stalls, long_stalls, max_stall); end
    ds_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    int st, bad;
    bit ok;
    do_reset(M_STREAM);
    tick();
    bad = 0;
    for (int i = 1; i <= 17; i++) begin
      send_beat(8'(i), st, ok);
      if (!ok) bad++;
    end
    ds_rdy = 1'b0;
    tick();
    n_cmp++; if (b4_cnt !== 4'd1 || bad != 0) begin n_bad++; $display("FAIL wrap_cnt4: got %0d want 1", b4_cnt); end
    n_cmp++; if (beat_cnt !== 16'd17) begin n_bad++; $display("FAIL wrap_cnt16: got %0d want 17", beat_cnt); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_delay_short();
    test_delay_long();
    test_block();
    test_abort_and_mode_change();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
